screen_sequencer: RTL and testbench

Registered controller that decides which of the three VGA renderers (game board, win screen, lose screen) drives the pins. It changes the selection only on frame boundaries. With blanking compiled in, it inserts one black frame between screens. It holds the result screen for a minimum number of frames, then accepts a restart request and issues a one-cycle restart pulse to the game logic. It runs on the VGA display clock and sits between the game controller's `won`/`lost` flags and the top-level RGB/sync output mux.

---
 rtl/screen_sequencer_if.sv | 20 ++
 rtl/screen_sequencer.sv | 92 +++++++++
 tb/tb_screen_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/screen_sequencer_if.sv
// screen_sequencer_if: game-flag, frame-timing and restart handshake between
// the game side (master) and the screen sequencer (slave).
interface screen_sequencer_if;
    logic       won;
    logic       lost;
    logic       frame_end;
    logic       restart_req;
    logic [1:0] sel;
    logic       blank;
    logic       hold_done;
    logic       restart_ack;
    modport master (
        output won, lost, frame_end, restart_req,
        input  sel, blank, hold_done, restart_ack
    );
    modport slave (
        input  won, lost, frame_end, restart_req,
        output sel, blank, hold_done, restart_ack
    );
endinterface

// File: rtl/screen_sequencer.sv
// screen_sequencer: frame-aligned game/win/lose renderer select with result hold and restart pulse.
// Define SEQ_BLANK_EN to insert one black frame between screens.
module screen_sequencer #(
    parameter int HOLD_FRAMES = 180,
    parameter int CNT_W       = 8
) (
    input logic dclk,
    input logic clr,
    screen_sequencer_if.slave bus
);
`ifdef SEQ_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_FRAMES);
    typedef enum logic [1:0] {GAME, FADE_IN, RESULT, FADE_OUT} state_t;
    state_t           state;
    logic             pending;
    logic             res_win;
    logic             req_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       res_sel;
    logic             req_edge;
    assign res_sel  = res_win ? 2'b01 : 2'b10;
    assign req_edge = bus.restart_req & ~req_q;
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state           <= GAME;
            pending         <= 1'b0;
            res_win         <= 1'b0;
            req_q           <= 1'b0;
            cnt             <= '0;
            bus.sel         <= 2'b00;
            bus.blank       <= 1'b0;
            bus.hold_done   <= 1'b0;
            bus.restart_ack <= 1'b0;
        end else begin
            req_q           <= bus.restart_req;
            bus.restart_ack <= 1'b0;
            unique case (state)
                GAME: begin
                    // Only the registered pending flag qualifies a boundary, so a flag
                    // arriving with frame_end waits for the next one.
                    if (pending && bus.frame_end) begin
                        pending <= 1'b0;
                        if (BLANK_EN) begin
                            state     <= FADE_IN;
                            bus.blank <= 1'b1;
                        end else begin
                            state         <= RESULT;
                            bus.sel       <= res_sel;
                            cnt           <= '0;
                            bus.hold_done <= (HOLD == '0);
                        end
                    end else if (bus.won || bus.lost) begin
                        pending <= 1'b1;
                        res_win <= bus.won;
                    end
                end
                FADE_IN: begin
                    if (bus.frame_end) begin
                        state         <= RESULT;
                        bus.sel       <= res_sel;
                        bus.blank     <= 1'b0;
                        cnt           <= '0;
                        bus.hold_done <= (HOLD == '0);
                    end
                end
                RESULT: begin
                    // An accepted restart outranks a coincident frame_end.
                    if (req_edge && bus.hold_done) begin
                        state           <= FADE_OUT;
                        bus.restart_ack <= 1'b1;
                        bus.blank       <= BLANK_EN;
                        bus.hold_done   <= 1'b0;
                    end else if (bus.frame_end && cnt != HOLD) begin
                        cnt           <= cnt + 1'b1;
                        bus.hold_done <= (cnt + 1'b1 == HOLD);
                    end
                end
                FADE_OUT: begin
                    if (bus.frame_end && !bus.won && !bus.lost) begin
                        state     <= GAME;
                        bus.sel   <= 2'b00;
                        bus.blank <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed self-checking bench for screen_sequencer with HOLD_FRAMES=3.
module tb_screen_sequencer;
`ifdef SEQ_BLANK_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif
    logic dclk = 1'b0;
    logic clr  = 1'b1;
    int   checks = 0;
    int   errors = 0;
    screen_sequencer_if bus();
    screen_sequencer #(.HOLD_FRAMES(3), .CNT_W(8)) dut (
        .dclk(dclk),
        .clr (clr),
        .bus (bus.slave)
    );
    always #5 dclk = ~dclk;

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic frame();
        bus.frame_end = 1'b1;
        tick();
        bus.frame_end = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        tick();
        tick();
        checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL reset_sel sel=%b exp=00", bus.sel); end
        checks++; if (bus.blank !== 1'b0) begin errors++; $display("FAIL reset_blank blank=%b exp=0", bus.blank); end
        checks++; if (bus.hold_done !== 1'b0) begin errors++; $display("FAIL reset_hold hold_done=%b exp=0", bus.hold_done); end
        checks++; if (bus.restart_ack !== 1'b0) begin errors++; $display("FAIL reset_ack restart_ack=%b exp=0", bus.restart_ack); end
        clr = 1'b0;
        tick();
    endtask

    // Raise the flags for one cycle, then walk through the (optional) blank frame into RESULT.
    task automatic enter_result(input logic w, input logic l, input logic [1:0] exp, input string name);
        bus.won  = w;
        bus.lost = l;
        tick();
        bus.won  = 1'b0;
        bus.lost = 1'b0;
        tick();
        checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL %s_pre_sel sel=%b exp=00", name, bus.sel); end
        frame();
        checks++; if (bus.blank !== BLK) begin errors++; $display("FAIL %s_fade_blank blank=%b exp=%b", name, bus.blank, BLK); end
        checks++; if (bus.sel !== (BLK ? 2'b00 : exp)) begin errors++; $display("FAIL %s_fade_sel sel=%b exp=%b", name, bus.sel, BLK ? 2'b00 : exp); end
        repeat (BLK) frame();
        checks++; if (bus.sel !== exp) begin errors++; $display("FAIL %s_result_sel sel=%b exp=%b", name, bus.sel, exp); end
        checks++; if (bus.blank !== 1'b0) begin errors++; $display("FAIL %s_result_blank blank=%b exp=0", name, bus.blank); end
        checks++; if (bus.hold_done !== 1'b0) begin errors++; $display("FAIL %s_result_hold hold_done=%b exp=0", name, bus.hold_done); end
    endtask

    task automatic leave_result(input string name);
        repeat (3) frame();
        checks++; if (bus.hold_done !== 1'b1) begin errors++; $display("FAIL %s_hold_done hold_done=%b exp=1", name, bus.hold_done); end
        bus.restart_req = 1'b1;
        tick();
        checks++; if (bus.restart_ack !== 1'b1) begin errors++; $display("FAIL %s_ack restart_ack=%b exp=1", name, bus.restart_ack); end
        checks++; if (bus.blank !== BLK) begin errors++; $display("FAIL %s_out_blank blank=%b exp=%b", name, bus.blank, BLK); end
        tick();
        checks++; if (bus.restart_ack !== 1'b0) begin errors++; $display("FAIL %s_ack_len restart_ack=%b exp=0", name, bus.restart_ack); end
        bus.restart_req = 1'b0;
        frame();
        checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL %s_game_sel sel=%b exp=00", name, bus.sel); end
        checks++; if (bus.blank !== 1'b0) begin errors++; $display("FAIL %s_game_blank blank=%b exp=0", name, bus.blank); end
    endtask

    task automatic test_won_pulse();
        enter_result(1'b1, 1'b0, 2'b01, "won");
        leave_result("won");
    endtask

    task automatic test_priority();
        enter_result(1'b1, 1'b1, 2'b01, "both");
        leave_result("both");
        enter_result(1'b0, 1'b1, 2'b10, "lost");
        leave_result("lost");
    endtask

    task automatic test_hold_and_fade_out();
        enter_result(1'b0, 1'b1, 2'b10, "hold");
        frame();
        frame();
        checks++; if (bus.hold_done !== 1'b0) begin errors++; $display("FAIL hold_early hold_done=%b exp=0", bus.hold_done); end
        bus.restart_req = 1'b1;
        tick();
        checks++; if (bus.restart_ack !== 1'b0) begin errors++; $display("FAIL hold_early_ack restart_ack=%b exp=0", bus.restart_ack); end
        frame();
        checks++; if (bus.hold_done !== 1'b1) begin errors++; $display("FAIL hold_third hold_done=%b exp=1", bus.hold_done); end
        tick();
        checks++; if (bus.restart_ack !== 1'b0) begin errors++; $display("FAIL hold_level_ack restart_ack=%b exp=0", bus.restart_ack); end
        bus.restart_req = 1'b0;
        tick();
        bus.restart_req = 1'b1;
        tick();
        checks++; if (bus.restart_ack !== 1'b1) begin errors++; $display("FAIL hold_ack restart_ack=%b exp=1", bus.restart_ack); end
        checks++; if (bus.blank !== BLK) begin errors++; $display("FAIL hold_out_blank blank=%b exp=%b", bus.blank, BLK); end
        tick();
        checks++; if (bus.restart_ack !== 1'b0) begin errors++; $display("FAIL hold_ack_len restart_ack=%b exp=0", bus.restart_ack); end
        bus.restart_req = 1'b0;
        bus.lost = 1'b1;
        repeat (2) begin
            frame();
            checks++; if (bus.sel !== 2'b10) begin errors++; $display("FAIL stuck_sel sel=%b exp=10", bus.sel); end
            checks++; if (bus.blank !== BLK) begin errors++; $display("FAIL stuck_blank blank=%b exp=%b", bus.blank, BLK); end
        end
        bus.lost = 1'b0;
        frame();
        checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL release_sel sel=%b exp=00", bus.sel); end
        checks++; if (bus.blank !== 1'b0) begin errors++; $display("FAIL release_blank blank=%b exp=0", bus.blank); end
    endtask

    task automatic test_restart_with_frame();
        enter_result(1'b1, 1'b0, 2'b01, "coin");
        repeat (3) frame();
        bus.restart_req = 1'b1;
        bus.frame_end   = 1'b1;
        tick();
        bus.restart_req = 1'b0;
        bus.frame_end   = 1'b0;
        checks++; if (bus.restart_ack !== 1'b1) begin errors++; $display("FAIL coin_ack restart_ack=%b exp=1", bus.restart_ack); end
        checks++; if (bus.sel !== 2'b01) begin errors++; $display("FAIL coin_sel sel=%b exp=01", bus.sel); end
        checks++; if (bus.blank !== BLK) begin errors++; $display("FAIL coin_blank blank=%b exp=%b", bus.blank, BLK); end
        frame();
        checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL coin_game_sel sel=%b exp=00", bus.sel); end
    endtask

    task automatic test_flag_with_frame();
        bus.won       = 1'b1;
        bus.frame_end = 1'b1;
        tick();
        bus.won       = 1'b0;
        bus.frame_end = 1'b0;
        checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL same_sel sel=%b exp=00", bus.sel); end
        checks++; if (bus.blank !== 1'b0) begin errors++; $display("FAIL same_blank blank=%b exp=0", bus.blank); end
        frame();
        checks++; if (bus.blank !== BLK) begin errors++; $display("FAIL same_next_blank blank=%b exp=%b", bus.blank, BLK); end
        checks++; if (bus.sel !== (BLK ? 2'b00 : 2'b01)) begin errors++; $display("FAIL same_next_sel sel=%b exp=%b", bus.sel, BLK ? 2'b00 : 2'b01); end
        repeat (BLK) frame();
        checks++; if (bus.sel !== 2'b01) begin errors++; $display("FAIL same_result_sel sel=%b exp=01", bus.sel); end
        leave_result("same");
    endtask

    task automatic test_clr_mid();
        enter_result(1'b1, 1'b0, 2'b01, "clr");
        repeat (3) frame();
        clr             = 1'b1;
        bus.restart_req = 1'b1;
        #1;
        checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL clr_sel sel=%b exp=00", bus.sel); end
        checks++; if (bus.hold_done !== 1'b0) begin errors++; $display("FAIL clr_hold hold_done=%b exp=0", bus.hold_done); end
        tick();
        checks++; if (bus.restart_ack !== 1'b0) begin errors++; $display("FAIL clr_ack restart_ack=%b exp=0", bus.restart_ack); end
        clr             = 1'b0;
        bus.restart_req = 1'b0;
        tick();
        checks++; if (bus.restart_ack !== 1'b0) begin errors++; $display("FAIL clr_ack_after restart_ack=%b exp=0", bus.restart_ack); end
        checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL clr_sel_after sel=%b exp=00", bus.sel); end
    endtask

    initial begin
        bus.won         = 1'b0;
        bus.lost        = 1'b0;
        bus.frame_end   = 1'b0;
        bus.restart_req = 1'b0;
        test_reset();
        test_won_pulse();
        test_priority();
        test_hold_and_fade_out();
        test_restart_with_frame();
        test_flag_with_frame();
        test_clr_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
